// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// led_matrix_pkg : shared encodings for the RGB LED matrix color stage
// Revision: 1.0
// ============================================================================
package led_matrix_pkg;

   typedef enum logic {
      RISE = 1'b0,
      FALL = 1'b1
   } dir_state_t;

   // Matrix LEDs are driven active-low.
   localparam logic LED_ON  = 1'b0;
   localparam logic LED_OFF = 1'b1;

   function automatic int duty_max_of(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/period_step_div.sv
`default_nettype none
// ============================================================================
// period_step_div : counts PWM period wraps and pulses step every
//                   STEP_PERIODS wraps
// Revision: 1.0
// ============================================================================
module period_step_div #(
   parameter int STEP_PERIODS = 192
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic en,
   output logic step
);

   localparam int SDIV_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(STEP_PERIODS - 1);

   logic [SDIV_W-1:0] sdiv;

   assign step = en && tick && (sdiv == SDIV_LAST);

   // Ticks are ignored while idle, so sdiv holds its value across pauses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdiv <= '0;
      end else if (en && tick) begin
         sdiv <= (sdiv == SDIV_LAST) ? '0 : sdiv + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_breather.sv
`default_nettype none
// ============================================================================
// pwm_breather : breathing PWM blanking generator for the LED matrix
// Revision: 1.0
// ============================================================================
module pwm_breather
   import led_matrix_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int STEP_PERIODS = 192
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             hold,
   output logic             pwm_out,
   output logic             up_down,
   output logic [CNT_W-1:0] duty,
   output logic             period_end
);

   localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(duty_max_of(CNT_W));
   localparam logic [CNT_W-1:0] DUTY_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] duty_next;
   dir_state_t       state;
   dir_state_t       state_next;
   logic             wrap;
   logic             step;

   assign wrap = en && (cnt == DUTY_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         pwm_out    <= LED_OFF;
         period_end <= 1'b0;
      end else begin
         if (en) begin
            cnt <= cnt + 1'b1;
         end
         period_end <= wrap;
         pwm_out    <= (en && (cnt < duty)) ? LED_ON : LED_OFF;
      end
   end

   // hold is sampled only at the wrap, so it never disturbs a running period.
   period_step_div #(
      .STEP_PERIODS (STEP_PERIODS)
   ) u_step_div (
      .clk  (clk),
      .rst  (rst),
      .tick (wrap && !hold),
      .en   (en),
      .step (step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RISE;
         duty  <= '0;
      end else begin
         state <= state_next;
         duty  <= duty_next;
      end
   end

   always_comb begin
      state_next = state;
      duty_next  = duty;
      if (step) begin
         case (state)
            RISE: begin
               if (duty == DUTY_MAX) begin
                  state_next = FALL;
                  duty_next  = DUTY_MAX - DUTY_ONE;
               end else begin
                  duty_next = duty + DUTY_ONE;
               end
            end
            FALL: begin
               if (duty == '0) begin
                  state_next = RISE;
                  duty_next  = DUTY_ONE;
               end else begin
                  duty_next = duty - DUTY_ONE;
               end
            end
            default: begin
               state_next = RISE;
               duty_next  = '0;
            end
         endcase
      end
   end

   assign up_down = (state == RISE);

endmodule
`default_nettype wire
